// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the 8-stage in-order pipeline.
// Merges stage stall requests, times multi-cycle MDU ops and sequences redirects.
module pipe_ctrl #(
   parameter int STALL_W = 8,
   parameter int MDU_LAT = 33,
   parameter int PC_W    = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_if,
   input  logic               req_id,
   input  logic               req_mem1,
   input  logic               req_mem2,
   input  logic               mdu_start,
   input  logic               br_valid,
   input  logic [PC_W-1:0]    br_pc,
   input  logic               trap_valid,
   input  logic [PC_W-1:0]    trap_pc,
   input  logic               redirect_ack,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic               br_flush,
   output logic               redirect_valid,
   output logic [PC_W-1:0]    redirect_pc,
   output logic               mdu_busy,
   output logic               mdu_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [5:0] LAT_M1 = 6'(MDU_LAT - 1);

   logic [1:0]         r_state;
   logic [5:0]         r_count;
   logic               r_redirValid;
   logic [PC_W-1:0]    r_redirPc;

   logic               w_live;
   logic               w_memStall;
   logic               w_mduAccept;
   logic               w_brAccept;
   logic [STALL_W-1:0] w_stall;

   function automatic logic [STALL_W-1:0] stallMask(input int k);
      stallMask = '0;
      for (int i = 0; i < STALL_W; i++) begin
         if (i <= k) stallMask[i] = 1'b1;
      end
   endfunction

   assign w_live      = !rst;
   assign w_memStall  = req_mem1 | req_mem2;
   // The start cycle itself already holds EX, so an accepted start stalls stage 4.
   assign w_mduAccept = w_live & mdu_start & (r_state == S_IDLE) & !w_memStall & !trap_valid;

   always_comb begin
      w_stall = '0;
      if (w_live && !trap_valid) begin
         if (req_mem2)                                w_stall = stallMask(6);
         else if (req_mem1)                           w_stall = stallMask(5);
         else if ((r_state == S_BUSY) || w_mduAccept) w_stall = stallMask(4);
         else if (req_id)                             w_stall = stallMask(3);
         else if (req_if)                             w_stall = stallMask(1);
      end
   end

   assign w_brAccept = w_live & br_valid & !w_stall[4] & !trap_valid;

   // Counter holds the cycles remaining in the op, including the current one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else if (trap_valid) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_mduAccept) begin
                  r_count <= LAT_M1;
                  r_state <= (LAT_M1 == 6'd1) ? S_DONE : S_BUSY;
               end
            end
            S_BUSY: begin
               if (!w_stall[5]) begin
                  r_count <= r_count - 6'd1;
                  if (r_count == 6'd2) r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (!w_stall[5]) begin
                  r_count <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_redirValid <= 1'b0;
         r_redirPc    <= '0;
      end else if (trap_valid) begin
         r_redirValid <= 1'b1;
         r_redirPc    <= trap_pc;
      end else if (w_brAccept) begin
         r_redirValid <= 1'b1;
         r_redirPc    <= br_pc;
      end else if (redirect_ack) begin
         r_redirValid <= 1'b0;
      end
   end

   assign stall          = w_stall;
   assign flush          = w_live & trap_valid;
   assign br_flush       = w_brAccept | r_redirValid;
   assign redirect_valid = r_redirValid;
   assign redirect_pc    = r_redirPc;
   assign mdu_busy       = (r_state != S_IDLE);
   assign mdu_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// compared against a remaining-cycles / pending-redirect reference model.
module tb_pipe_ctrl;

   localparam int STALL_W = 8;
   localparam int MDU_LAT = 33;
   localparam int PC_W    = 64;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_if, req_id, req_mem1, req_mem2, mdu_start;
   logic               br_valid, trap_valid, redirect_ack;
   logic [PC_W-1:0]    br_pc, trap_pc;
   logic [STALL_W-1:0] stall;
   logic               flush, br_flush, redirect_valid, mdu_busy, mdu_done;
   logic [PC_W-1:0]    redirect_pc;
   logic [76:0]        outs;

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(.STALL_W(STALL_W), .MDU_LAT(MDU_LAT), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst),
      .req_if(req_if), .req_id(req_id), .req_mem1(req_mem1), .req_mem2(req_mem2),
      .mdu_start(mdu_start), .br_valid(br_valid), .br_pc(br_pc),
      .trap_valid(trap_valid), .trap_pc(trap_pc), .redirect_ack(redirect_ack),
      .stall(stall), .flush(flush), .br_flush(br_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mdu_busy(mdu_busy), .mdu_done(mdu_done)
   );

   assign outs = {stall, flush, br_flush, redirect_valid, redirect_pc, mdu_busy, mdu_done};

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic iIf, input logic iId, input logic iM1,
                                input logic iM2, input logic iSt, input logic iBr,
                                input logic [63:0] iBp, input logic iTr,
                                input logic [63:0] iTp, input logic iAck);
      req_if = iIf; req_id = iId; req_mem1 = iM1; req_mem2 = iM2; mdu_start = iSt;
      br_valid = iBr; br_pc = iBp; trap_valid = iTr; trap_pc = iTp; redirect_ack = iAck;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1, 1, 1, 1, 1, 1, 64'hDEAD, 1, 64'hBEEF, 0);
      #2;
      checks++;
      if (outs !== 77'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
      if (outs !== 77'd0) errors++;
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #2;
      checks++;
      if (outs !== 77'd0) begin
         errors++;
         $display("[TB] FAIL reset_release: got %h expected 0", outs);
      end
   endtask

   task automatic test_mdu_timing();
      for (int c = 0; c <= 33; c++) begin
         @(negedge clk);
         applyStimulus(0, 0, 0, 0, c == 0, 0, 0, 0, 0, 0);
         #2;
         checks++;
         if (stall !== ((c <= 31) ? 8'h1F : 8'h00)) begin
            errors++;
            $display("[TB] FAIL mdu_stall c=%0d: got %h expected %h", c, stall, (c <= 31) ? 8'h1F : 8'h00);
         end
         checks++;
         if (mdu_done !== 1'(c == 32)) begin
            errors++;
            $display("[TB] FAIL mdu_done c=%0d: got %b expected %b", c, mdu_done, c == 32);
         end
         checks++;
         if (mdu_busy !== 1'(c >= 1 && c <= 32)) begin
            errors++;
            $display("[TB] FAIL mdu_busy c=%0d: got %b expected %b", c, mdu_busy, c >= 1 && c <= 32);
         end
      end
   endtask

   task automatic test_stall_priority();
      logic [7:0] expS [5] = '{8'h3F, 8'h0F, 8'h00, 8'h03, 8'h7F};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         applyStimulus(c == 3, c <= 1, c == 0, c == 4, 0, 0, 0, 0, 0, 0);
         #2;
         checks++;
         if (stall !== expS[c]) begin
            errors++;
            $display("[TB] FAIL stall_priority step=%0d: got %h expected %h", c, stall, expS[c]);
         end
      end
   endtask

   task automatic test_redirect();
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         applyStimulus(0, 0, 0, 0, 0, c == 0, 64'h8000_0040, 0, 0, c == 4);
         #2;
         checks++;
         if ({br_flush, redirect_valid} !== {1'(c <= 4), 1'(c >= 1 && c <= 4)}) begin
            errors++;
            $display("[TB] FAIL redirect c=%0d: got flush/valid %b%b", c, br_flush, redirect_valid);
         end
         if (c >= 1 && c <= 4) begin
            checks++;
            if (redirect_pc !== 64'h8000_0040) begin
               errors++;
               $display("[TB] FAIL redirect_pc c=%0d: got %h expected 80000040", c, redirect_pc);
            end
         end
      end
   endtask

   task automatic test_trap();
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 1, 64'h100, 0, 0, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checks++;
      if ({mdu_busy, redirect_valid, redirect_pc} !== {2'b11, 64'h100}) begin
         errors++;
         $display("[TB] FAIL trap_setup: got busy=%b valid=%b pc=%h", mdu_busy, redirect_valid, redirect_pc);
      end
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 0);
      #2;
      checks++;
      if ({flush, stall} !== {1'b1, 8'h00}) begin
         errors++;
         $display("[TB] FAIL trap_flush: got flush=%b stall=%h expected 1/00", flush, stall);
      end
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2;
      checks++;
      if ({flush, mdu_busy, redirect_valid, redirect_pc} !== {3'b001, 64'h8000_0000}) begin
         errors++;
         $display("[TB] FAIL trap_after: got flush=%b busy=%b valid=%b pc=%h", flush, mdu_busy, redirect_valid, redirect_pc);
      end
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_blocked_branch();
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         applyStimulus(0, 0, c <= 1, 0, 0, c <= 2, 64'h2000, 0, 0, 0);
         #2;
         checks++;
         if ({br_flush, redirect_valid} !== {1'(c >= 2), 1'(c == 3)}) begin
            errors++;
            $display("[TB] FAIL blocked_branch c=%0d: got flush/valid %b%b expected %b%b",
                     c, br_flush, redirect_valid, c >= 2, c == 3);
         end
      end
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 1, 64'h3000, 0, 0, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      checks++;
      if ({mdu_busy, redirect_valid} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL async_setup: got busy/valid %b%b expected 11", mdu_busy, redirect_valid);
      end
      rst = 1'b1;
      req_mem2 = 1'b1;
      #1;
      checks++;
      if (outs !== 77'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h expected 0", outs);
      end
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      #2;
      checks++;
      if (outs !== 77'd0) begin
         errors++;
         $display("[TB] FAIL async_release: got %h expected 0", outs);
      end
   endtask

   // Model tracks cycles left in the MDU op and the pending redirect target.
   task automatic test_random();
      int         mRemain = 0;
      logic       mValid  = 1'b0;
      logic [63:0] mPc    = '0;
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         logic iIf, iId, iM1, iM2, iSt, iBr, iTr, iAck, memS, acc, brA;
         logic [63:0] iBp, iTp;
         logic [7:0] expS;
         logic [76:0] expO;
         int k;
         @(negedge clk);
         iIf = ($urandom_range(0, 5) == 0); iId = ($urandom_range(0, 5) == 0);
         iM1 = ($urandom_range(0, 7) == 0); iM2 = ($urandom_range(0, 9) == 0);
         iSt = ($urandom_range(0, 12) == 0); iBr = ($urandom_range(0, 5) == 0);
         iTr = ($urandom_range(0, 70) == 0); iAck = ($urandom_range(0, 2) == 0);
         iBp = {$urandom, $urandom}; iTp = {$urandom, $urandom};
         applyStimulus(iIf, iId, iM1, iM2, iSt, iBr, iBp, iTr, iTp, iAck);
         #2;
         memS = iM1 | iM2;
         acc  = iSt && (mRemain == 0) && !memS && !iTr;
         if (iTr) k = -1;
         else if (iM2) k = 6;
         else if (iM1) k = 5;
         else if (mRemain > 1 || acc) k = 4;
         else if (iId) k = 3;
         else if (iIf) k = 1;
         else k = -1;
         expS = '0;
         for (int i = 0; i <= k; i++) expS[i] = 1'b1;
         brA  = iBr && !iTr && !expS[4];
         expO = {expS, iTr, brA | mValid, mValid, mPc, 1'(mRemain > 0), 1'(mRemain == 1)};
         checks++;
         if (outs !== expO) begin
            errors++;
            $display("[TB] FAIL random n=%0d: got %h expected %h", n, outs, expO);
         end
         if (iTr) begin
            mRemain = 0; mValid = 1'b1; mPc = iTp;
         end else begin
            if (acc) mRemain = MDU_LAT - 1;
            else if (mRemain > 0 && !memS) mRemain--;
            if (brA) begin
               mValid = 1'b1; mPc = iBp;
            end else if (iAck) mValid = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_mdu_timing();
      test_stall_priority();
      test_redirect();
      test_trap();
      test_blocked_branch();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/redirect controller for the 8-stage in-order pipeline (0 PC, 1 IF1, 2 IF2, 3 ID, 4 EX, 5 MEM1, 6 MEM2, 7 WB).
- Merges per-stage stall requests into the shared stall bus that every stage register consumes.
- Times multi-cycle MDU operations issued from EX.
- Sequences branch redirects and trap flushes toward fetch using a valid/ack handshake.

Parameters:
STALL_W, 8, stall bus width; one bit per stage register, index = stage number
MDU_LAT, 33, cycles an MDU op occupies EX, counted from the start cycle inclusive; legal range 2..63
PC_W, 64, width of redirect/trap PCs

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_if  in  1  IF1 not ready (icache miss)
req_id  in  1  ID load-use hazard
req_mem1  in  1  MEM1 waiting on dcache
req_mem2  in  1  MEM2 waiting on load data
mdu_start  in  1  EX issues a multi-cycle mul/div this cycle
br_valid  in  1  EX resolved a taken/mispredicted branch
br_pc  in  PC_W  branch target
trap_valid  in  1  MEM2 raises exception/trap
trap_pc  in  PC_W  trap vector
redirect_ack  in  1  fetch accepted redirect this cycle
stall  out  STALL_W  stall bus; bit i=1 holds stage register i
flush  out  1  pipeline-wide flush (all stage registers cleared)
br_flush  out  1  clear stage registers 1..3 (IF1, IF2, ID)
redirect_valid  out  1  redirect request to PC stage
redirect_pc  out  PC_W  redirect target
mdu_busy  out  1  MDU op in flight
mdu_done  out  1  final MDU cycle; EX result valid

Behaviour:
- Reset (async, rst=1): FSM=IDLE, counter=0, pending redirect cleared.
- Outputs while in reset: stall=0, flush=0, br_flush=0, redirect_valid=0, redirect_pc=0, mdu_busy=0, mdu_done=0.
- Stall merge (combinational): compute stage k = highest active request.
  - req_mem2→6, req_mem1→5, (mdu_busy & !mdu_done)→4, req_id→3, req_if→1.
  - stall[k:0]=1, all higher bits 0; no request → stall=0.
  - A stage with stall[i]=1 and stall[i+1]=0 bubbles its output register; stage registers implement this, not this block.
- MDU FSM: IDLE→BUSY on mdu_start & !stall[4] & !flush; counter loads MDU_LAT-1.
  - BUSY: decrement counter each cycle in which stall[5]=0.
  - BUSY: counter==1 → DONE.
  - DONE: mdu_done=1 for one cycle, then →IDLE. If stall[5]=1 in DONE, remain DONE and keep mdu_done=1.
  - mdu_busy=1 in BUSY and DONE.
  - mdu_start while busy is ignored (illegal).
- Branch: br_valid accepted only when stall[4]=0 and no trap this cycle.
  - Acceptance loads pending redirect: redirect_valid=1 and redirect_pc=br_pc from the next cycle.
  - br_flush=1 in the acceptance cycle and in every cycle while redirect_valid=1.
  - Redirect is held until the cycle redirect_ack=1; cleared the following cycle.
  - A new accepted br_valid while pending overwrites redirect_pc; ack and new branch in the same cycle → new branch wins.
- Trap (highest priority): trap_valid=1 → flush=1 in that cycle (combinational).
  - Pending redirect replaced by trap_pc next cycle; redirect_valid=1 until ack.
  - MDU FSM forced to IDLE and counter cleared; same-cycle br_valid and mdu_start are dropped.
  - stall forced to 0 in a trap cycle.
- All state registers update on posedge clk. rst mid-operation aborts MDU and pending redirect immediately.

Test Plan:
- MDU timing: MDU_LAT=33, mdu_start pulse at cycle 10, no other requests → stall=8'h1F cycles 10..41, mdu_done=1 cycle 42, stall=0 cycle 42, mdu_busy=0 cycle 43.
- Stall priority: req_id=1 and req_mem1=1 together → stall=8'h3F; drop req_mem1 → stall=8'h0F; drop req_id → stall=8'h00.
- Redirect handshake: br_valid=1, br_pc=64'h8000_0040 with redirect_ack low 3 cycles → redirect_valid=1 and br_flush=1 for 3 cycles; ack on 4th → redirect_valid=0 next cycle.
- Trap preemption: pending branch redirect to 64'h100 plus MDU in BUSY; trap_valid=1, trap_pc=64'h8000_0000 → flush=1 same cycle, redirect_pc=64'h8000_0000 next cycle, mdu_busy=0 next cycle.
- Blocked branch: req_mem1=1 (stall[4]=1) with br_valid=1 → no redirect; release req_mem1 while br_valid is held → redirect_valid=1 the following cycle.
- Async reset during MDU BUSY with pending redirect: assert rst mid-cycle → all outputs 0 without waiting for a clock edge; after release, stall=0 and FSM in IDLE.
